// File: rtl/alu_control_unit.sv
// Multi-cycle accumulator controller: fetches from instruction memory, reads
// operands from data memory, sequences the external ALU and captures its result.
module alu_control_unit #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 12,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] acc,
  output logic              z_flag,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_STORE  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_CLR   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;

  localparam logic [2:0] SEL_ADD   = 3'b000;
  localparam logic [2:0] SEL_SUB   = 3'b001;
  localparam logic [2:0] SEL_MUL   = 3'b010;
  localparam logic [2:0] SEL_PASSA = 3'b011;
  localparam logic [2:0] SEL_PASSB = 3'b100;
  localparam logic [2:0] SEL_ZERO  = 3'b101;
  localparam logic [2:0] SEL_FIN   = 3'b110;

  state_t              state, state_n;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   mdr;
  logic                halt_pulse;
  logic [3:0]          fetch_op;
  logic [3:0]          ir_op;
  logic [ADDR_W-1:0]   fetch_addr;

  // DECODE steers on the word arriving from memory; IR only holds it afterwards.
  assign fetch_op   = imem_rdata[DATA_W-1 -: 4];
  assign fetch_addr = imem_rdata[ADDR_W-1:0];
  assign ir_op      = ir[DATA_W-1 -: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      mdr        <= '0;
      acc        <= '0;
      z_flag     <= 1'b0;
      halt_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      halt_pulse <= (state == S_DECODE) && (state_n == S_HALT);
      case (state)
        S_IDLE: begin
          if (start) pc <= ADDR_W'(START_ADDR);
        end
        S_DECODE: begin
          ir <= imem_rdata;
          case (fetch_op)
            OP_JMP:  pc <= fetch_addr;
            OP_JZ:   pc <= z_flag ? fetch_addr : pc + 1'b1;
            default: pc <= pc + 1'b1;
          endcase
        end
        S_EXEC: begin
          if (ir_op != OP_CLR) mdr <= dmem_rdata;
        end
        S_WB: begin
          acc <= alu_out;
          if (ir_op == OP_ADD || ir_op == OP_SUB) z_flag <= alu_z;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (fetch_op)
          OP_LOAD, OP_ADD, OP_SUB, OP_MUL: state_n = S_READ;
          OP_CLR:   state_n = S_EXEC;
          OP_STORE: state_n = S_STORE;
          OP_HALT:  state_n = S_HALT;
          default:  state_n = S_FETCH;
        endcase
      end
      S_READ:   state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
      S_WB:     state_n = S_FETCH;
      S_STORE:  state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
  end

  // The ALU only re-evaluates on select changes, so idle states park on pass-A.
  always_comb begin
    alu_select = SEL_PASSA;
    if (state == S_EXEC || state == S_WB) begin
      case (ir_op)
        OP_LOAD: alu_select = SEL_PASSB;
        OP_ADD:  alu_select = SEL_ADD;
        OP_SUB:  alu_select = SEL_SUB;
        OP_MUL:  alu_select = SEL_MUL;
        OP_CLR:  alu_select = SEL_ZERO;
        default: alu_select = SEL_PASSA;
      endcase
    end else if (state == S_HALT && halt_pulse) begin
      alu_select = SEL_FIN;
    end
  end

  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);
  assign dmem_we    = (state == S_STORE);
  assign imem_addr  = pc;
  assign dmem_addr  = ir[ADDR_W-1:0];
  assign dmem_wdata = acc;
  assign alu_a      = acc;
  assign alu_b      = mdr;
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: memory and ALU models, directed programs, and a
// queue-based scoreboard checked by a monitor on the falling clock edge.
module tb_alu_control_unit;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STORE = 3'd6;

  typedef struct {
    string       name;
    logic [15:0] acc;
    logic        z;
    logic [11:0] pc;
    logic        halted;
    logic        busy;
    logic [2:0]  sel;
    logic        we;
    int          mem_addr;  // -1: skip
    logic [15:0] mem_val;
    int          cycles;    // -1: skip
    int          we_cnt;    // -1: skip
    int          fin_cnt;   // -1: skip
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, halted, dmem_we, alu_z, z_flag;
  logic [11:0] pc, imem_addr, dmem_addr;
  logic [15:0] imem_rdata, dmem_rdata, dmem_wdata, alu_a, alu_b, alu_out, acc;
  logic [2:0]  alu_select, dbg_state;

  logic [15:0] imem [0:4095];
  logic [15:0] dmem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_addr = '0;
  logic [15:0] tb_data = '0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic snap_tog = 1'b0;
  logic tmo_tog  = 1'b0;

  always #5 clk = ~clk;

  alu_control_unit #(.DATA_W(16), .ADDR_W(12), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted), .pc(pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_z(alu_z), .acc(acc), .z_flag(z_flag),
    .dbg_state(dbg_state)
  );

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    else if (tb_we) dmem[tb_addr] <= tb_data;
    dmem_rdata <= dmem[dmem_addr];
    imem_rdata <= imem[imem_addr];
  end

  // Behavioural ALU.
  logic [31:0] prod;
  always_comb begin
    prod = 32'(alu_a) * 32'(alu_b);
    case (alu_select)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = prod[15:0];
      3'b100:  alu_out = alu_b;
      3'b101:  alu_out = 16'h0000;
      default: alu_out = alu_a;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic cmp(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  int busy_cnt = 0, we_cnt = 0, fin_cnt = 0, hcnt = 0;

  task automatic compare_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got output event with empty expected queue");
      return;
    end
    e = exp_q.pop_front();
    cmp({e.name, ".acc"},    acc,        e.acc);
    cmp({e.name, ".z"},      z_flag,     e.z);
    cmp({e.name, ".pc"},     pc,         e.pc);
    cmp({e.name, ".halted"}, halted,     e.halted);
    cmp({e.name, ".busy"},   busy,       e.busy);
    cmp({e.name, ".sel"},    alu_select, e.sel);
    cmp({e.name, ".we"},     dmem_we,    e.we);
    if (e.mem_addr >= 0) cmp({e.name, ".mem"}, dmem[e.mem_addr], e.mem_val);
    if (e.cycles >= 0)   cmp({e.name, ".cycles"}, busy_cnt, e.cycles);
    if (e.we_cnt >= 0)   cmp({e.name, ".we_cycles"}, we_cnt, e.we_cnt);
    if (e.fin_cnt >= 0)  cmp({e.name, ".finish_cycles"}, fin_cnt, e.fin_cnt);
  endtask

  initial begin : monitor
    logic snap_seen, tmo_seen;
    snap_seen = 1'b0;
    tmo_seen  = 1'b0;
    forever begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) begin
        busy_cnt = 0; we_cnt = 0; fin_cnt = 0; hcnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (dmem_we) we_cnt++;
        if (alu_select == 3'b110) fin_cnt++;
        if (halted) hcnt++;
      end
      if (hcnt == 3) compare_front();
      if (snap_tog != snap_seen) begin
        snap_seen = snap_tog;
        compare_front();
      end
      if (tmo_tog != tmo_seen) begin
        tmo_seen = tmo_tog;
        checks++; errors++;
        $display("FAIL timeout: got no DUT event within budget, expected one");
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic exp_t mk(input string nm, input logic [15:0] a, input logic z,
                              input logic [11:0] p, input int maddr, input logic [15:0] mval,
                              input int cyc, input int wec);
    exp_t e;
    e.name = nm; e.acc = a; e.z = z; e.pc = p;
    e.halted = 1'b1; e.busy = 1'b0; e.sel = 3'b011; e.we = 1'b0;
    e.mem_addr = maddr; e.mem_val = mval; e.cycles = cyc; e.we_cnt = wec; e.fin_cnt = 1;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic dpre(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic request_snapshot(input exp_t e);
    exp_q.push_back(e);
    #1 snap_tog = ~snap_tog;
  endtask

  task automatic wait_halt();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) begin seen = 1'b1; break; end
    end
    if (!seen) tmo_tog = ~tmo_tog;
    repeat (5) @(negedge clk);
  endtask

  // Per-opcode vectors: single instruction followed by HALT at address 1.
  logic [15:0] op_ins [9] = '{16'h0000, 16'h2010, 16'h6000, 16'h1010, 16'h3010,
                              16'h4010, 16'h5010, 16'h7001, 16'h8001};
  logic [15:0] op_acc [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h00A5, 16'h00A5,
                              16'hFF5B, 16'h0000, 16'h0000, 16'h0000};
  int          op_cyc [9] = '{4, 5, 6, 7, 7, 7, 7, 4, 4};
  string       op_nm  [9] = '{"nop", "store", "clr", "load", "add", "sub", "mul", "jmp", "jz_nt"};

  // ---------------- stimulus ----------------
  initial begin : main
    exp_t e;
    // Reset state, sampled while rst is held.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    e = mk("reset", 16'h0, 1'b0, 12'h000, -1, 16'h0, -1, -1);
    e.halted = 1'b0; e.fin_cnt = -1;
    request_snapshot(e);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset raised during the STORE cycle must abort the write.
    dpre(12'h050, 16'hBEEF);
    dpre(12'h051, 16'h1234);
    imem[0] = 16'h1051; imem[1] = 16'h2050; imem[2] = 16'h9000;
    pulse_start();
    begin : wait_store
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (dbg_state == ST_STORE) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      if (!seen) tmo_tog = ~tmo_tog;
    end
    #1 rst = 1'b1;
    e = mk("rst_mid_store", 16'h0, 1'b0, 12'h000, 12'h050, 16'hBEEF, -1, -1);
    e.halted = 1'b0; e.fin_cnt = -1;
    request_snapshot(e);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // LOAD/SUB to zero, JZ taken to 0x010, HALT there.
    do_reset();
    dpre(12'h100, 16'd5); dpre(12'h101, 16'd5);
    imem[0] = 16'h1100; imem[1] = 16'h4101; imem[2] = 16'h8010; imem[3] = 16'h9000;
    imem[12'h010] = 16'h9000;
    exp_q.push_back(mk("sub_jz", 16'h0000, 1'b1, 12'h011, -1, 16'h0, 14, 0));
    pulse_start();
    wait_halt();

    // MUL keeps low 16 bits; STORE writes once; start while busy and halted ignored.
    do_reset();
    dpre(12'h200, 16'h0003); dpre(12'h201, 16'h6000); dpre(12'h202, 16'h0000);
    imem[0] = 16'h1200; imem[1] = 16'h5201; imem[2] = 16'h2202; imem[3] = 16'h9000;
    exp_q.push_back(mk("mul_store", 16'h2000, 1'b0, 12'h004, 12'h202, 16'h2000, 15, 1));
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_halt();
    pulse_start();
    e = mk("start_in_halt", 16'h2000, 1'b0, 12'h004, 12'h202, 16'h2000, -1, -1);
    e.fin_cnt = -1;
    request_snapshot(e);
    repeat (2) @(negedge clk);

    // ADD wraps to zero (z=1), LOAD keeps z, JZ taken.
    do_reset();
    dpre(12'h300, 16'h0001); dpre(12'h301, 16'hFFFF); dpre(12'h007, 16'h0007);
    imem[0] = 16'h1300; imem[1] = 16'h3301; imem[2] = 16'h1007; imem[3] = 16'h8006;
    imem[4] = 16'h9000; imem[5] = 16'h0000; imem[6] = 16'h9000;
    exp_q.push_back(mk("add_wrap_jz", 16'h0007, 1'b1, 12'h007, -1, 16'h0, 19, 0));
    pulse_start();
    wait_halt();

    // JMP at 0xFFF over the PC wrap, then illegal opcode 0xC as NOP.
    do_reset();
    imem[0] = 16'h7FFF; imem[12'hFFF] = 16'h7005; imem[5] = 16'hC123; imem[6] = 16'h9000;
    exp_q.push_back(mk("wrap_illegal", 16'h0000, 1'b0, 12'h007, -1, 16'h0, 8, 0));
    pulse_start();
    wait_halt();

    // Per-opcode cycle counts.
    for (int k = 0; k < 9; k++) begin
      do_reset();
      dpre(12'h010, 16'h00A5);
      imem[0] = op_ins[k]; imem[1] = 16'h9000;
      exp_q.push_back(mk({"op_", op_nm[k]}, op_acc[k], 1'b0, 12'h002, 12'h010,
                         (k == 1) ? 16'h0000 : 16'h00A5, op_cyc[k], (k == 1) ? 1 : 0));
      pulse_start();
      wait_halt();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
